action_input_conditioner: RTL and testbench

ACTION_INPUT_CONDITIONER -- requirements
Module: action_input_conditioner

---
 rtl/action_input_conditioner_pkg.sv | 15 +
 rtl/action_input_conditioner_button_debouncer.sv | 48 ++++
 rtl/action_input_conditioner.sv | 91 +++++++++
 tb/tb_action_input_conditioner.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/action_input_conditioner_pkg.sv
// Shared game constants: action-button width, debounce default and action bit indices.
// Used by the input conditioner, the action converter and the board.
package action_input_conditioner_pkg;

    localparam int unsigned ACT_W_DFLT    = 6;
    localparam int unsigned DBNC_CNT_DFLT = 50000;

    localparam int unsigned ACT_UP    = 0;
    localparam int unsigned ACT_DOWN  = 1;
    localparam int unsigned ACT_LEFT  = 2;
    localparam int unsigned ACT_RIGHT = 3;
    localparam int unsigned ACT_FIRE  = 4;
    localparam int unsigned ACT_JUMP  = 5;

endpackage

// File: rtl/action_input_conditioner_button_debouncer.sv
// One raw button bit: two-flop synchronizer followed by a stable-count debouncer.
// level_nxt exposes the value level takes at the next edge so the parent can detect presses early.
module button_debouncer import action_input_conditioner_pkg::*; #(
    parameter int unsigned DBNC_CNT = DBNC_CNT_DFLT
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic level_nxt
);

    localparam int unsigned CW = (DBNC_CNT > 1) ? $clog2(DBNC_CNT) : 1;

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DBNC_CNT - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level     = level_q;
    assign level_nxt = level_d;

endmodule

// File: rtl/action_input_conditioner.sv
// Debounces both players' buttons, turns presses into a first-come pending action per player,
// and hands that action to the game on each tick.
module action_input_conditioner import action_input_conditioner_pkg::*; #(
    parameter int unsigned DBNC_CNT = DBNC_CNT_DFLT,
    parameter int unsigned ACT_W    = ACT_W_DFLT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ACT_W-1:0] plr_1_btn,
    input  logic [ACT_W-1:0] plr_2_btn,
    input  logic             tck,
    output logic [ACT_W-1:0] plr_1_act,
    output logic [ACT_W-1:0] plr_2_act,
    output logic             plr_1_pnd,
    output logic             plr_2_pnd
);

    logic [ACT_W-1:0] lvl_1, lvl_2, nxt_1, nxt_2;
    logic [ACT_W-1:0] press [2];
    logic [ACT_W-1:0] first [2];
    logic [ACT_W-1:0] act_q [2], act_d [2];
    logic [ACT_W-1:0] po_q [2], po_d [2];
    logic [1:0]       pv_q, pv_d;

    for (genvar b = 0; b < ACT_W; b++) begin : g_dbnc
        button_debouncer #(
            .DBNC_CNT (DBNC_CNT)
        ) u_dbnc_1 (
            .clk       (clk),
            .rst       (rst),
            .raw       (plr_1_btn[b]),
            .level     (lvl_1[b]),
            .level_nxt (nxt_1[b])
        );
        button_debouncer #(
            .DBNC_CNT (DBNC_CNT)
        ) u_dbnc_2 (
            .clk       (clk),
            .rst       (rst),
            .raw       (plr_2_btn[b]),
            .level     (lvl_2[b]),
            .level_nxt (nxt_2[b])
        );
    end

    // A press is the debounced level rising at the coming edge.
    assign press[0] = nxt_1 & ~lvl_1;
    assign press[1] = nxt_2 & ~lvl_2;

    // Isolate the lowest set bit (two's-complement trick).
    assign first[0] = press[0] & (~press[0] + ACT_W'(1));
    assign first[1] = press[1] & (~press[1] + ACT_W'(1));

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            act_d[p] = act_q[p];
            pv_d[p]  = pv_q[p];
            po_d[p]  = po_q[p];
            if (tck) begin
                act_d[p] = pv_q[p] ? po_q[p] : '0;
                pv_d[p]  = |press[p];
                po_d[p]  = first[p];
            end else if (!pv_q[p] && (|press[p])) begin
                pv_d[p] = 1'b1;
                po_d[p] = first[p];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < 2; p++) begin
                act_q[p] <= '0;
                po_q[p]  <= '0;
            end
            pv_q <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                act_q[p] <= act_d[p];
                po_q[p]  <= po_d[p];
            end
            pv_q <= pv_d;
        end
    end

    assign plr_1_act = act_q[0];
    assign plr_2_act = act_q[1];
    assign plr_1_pnd = pv_q[0];
    assign plr_2_pnd = pv_q[1];

endmodule

// File: tb/tb_action_input_conditioner.sv
// Self-checking bench: directed table, hand sequences for corner cases, and random stimulus
// against a reference model that debounces by looking at a window of past raw samples.
module tb_action_input_conditioner;

    localparam int AW   = 6;
    localparam int DBNC = 4;
    localparam int HL   = DBNC + 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tck = 1'b0;
    logic [AW-1:0] plr_1_btn = '0;
    logic [AW-1:0] plr_2_btn = '0;
    logic [AW-1:0] plr_1_act, plr_2_act;
    logic          plr_1_pnd, plr_2_pnd;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state
    bit m_hist [2][AW][HL];
    bit m_deb  [2][AW];
    int m_pend [2];
    int m_act  [2];

    typedef struct {
        logic [AW-1:0] p1;
        logic [AW-1:0] p2;
        logic          tck;
        logic [AW-1:0] e1;
        logic [AW-1:0] e2;
        logic          ep1;
        logic          ep2;
    } vec_t;

    vec_t tbl [21];

    action_input_conditioner #(
        .DBNC_CNT (DBNC),
        .ACT_W    (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .plr_1_btn (plr_1_btn),
        .plr_2_btn (plr_2_btn),
        .tck       (tck),
        .plr_1_act (plr_1_act),
        .plr_2_act (plr_2_act),
        .plr_1_pnd (plr_1_pnd),
        .plr_2_pnd (plr_2_pnd)
    );

    always #5 clk = ~clk;

    function automatic logic [AW-1:0] oh(input int i);
        logic [AW-1:0] v;
        v = '0;
        if (i >= 0) v[i] = 1'b1;
        return v;
    endfunction

    // Debounced level flips once the last DBNC synchronized samples all disagree with it.
    task automatic model_update();
        int first;
        bit all_diff;
        if (rst) begin
            for (int p = 0; p < 2; p++) begin
                for (int b = 0; b < AW; b++) begin
                    m_deb[p][b] = 1'b0;
                    for (int k = 0; k < HL; k++) m_hist[p][b][k] = 1'b0;
                end
                m_pend[p] = -1;
                m_act[p]  = -1;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                first = -1;
                for (int b = 0; b < AW; b++) begin
                    for (int k = HL - 1; k > 0; k--) m_hist[p][b][k] = m_hist[p][b][k-1];
                    m_hist[p][b][0] = (p == 0) ? plr_1_btn[b] : plr_2_btn[b];
                    all_diff = 1'b1;
                    for (int k = 2; k < HL; k++)
                        if (m_hist[p][b][k] == m_deb[p][b]) all_diff = 1'b0;
                    if (all_diff) begin
                        if (!m_deb[p][b] && first < 0) first = b;
                        m_deb[p][b] = !m_deb[p][b];
                    end
                end
                if (tck) begin
                    m_act[p]  = m_pend[p];
                    m_pend[p] = first;
                end else if (m_pend[p] < 0) begin
                    m_pend[p] = first;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #2;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check(input string name, input logic [AW-1:0] got, input logic [AW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic check_outs(input string name, input logic [AW-1:0] e1, input logic [AW-1:0] e2,
                              input logic ep1, input logic ep2);
        check({name, " p1_act"}, plr_1_act, e1);
        check({name, " p2_act"}, plr_2_act, e2);
        check({name, " p1_pnd"}, {5'b0, plr_1_pnd}, {5'b0, ep1});
        check({name, " p2_pnd"}, {5'b0, plr_2_pnd}, {5'b0, ep2});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tck = 1'b0;
        plr_1_btn = '0;
        plr_2_btn = '0;
        step();
        rst = 1'b0;
    endtask

    task automatic tick();
        tck = 1'b1;
        step();
        tck = 1'b0;
    endtask

    initial begin
        // Held press with tick at row 10, then a 3-cycle glitch on player 2 and a tick at row 20.
        for (int k = 0; k < 21; k++) begin
            tbl[k].p1  = 6'b000100;
            tbl[k].p2  = (k >= 12 && k <= 14) ? 6'b000001 : 6'b000000;
            tbl[k].tck = (k == 10 || k == 20);
            tbl[k].e1  = (k >= 10 && k < 20) ? 6'b000100 : 6'b000000;
            tbl[k].e2  = 6'b000000;
            tbl[k].ep1 = (k >= 5 && k <= 9);
            tbl[k].ep2 = 1'b0;
        end

        do_reset();
        check_outs("reset", '0, '0, 1'b0, 1'b0);

        for (int k = 0; k < 21; k++) begin
            plr_1_btn = tbl[k].p1;
            plr_2_btn = tbl[k].p2;
            tck       = tbl[k].tck;
            step();
            tck = 1'b0;
            check_outs($sformatf("table row %0d", k), tbl[k].e1, tbl[k].e2, tbl[k].ep1, tbl[k].ep2);
        end

        // Simultaneous presses resolve low; a later press while pending is dropped.
        do_reset();
        plr_1_btn = 6'b101000;
        run(5);
        check("prio pnd early", {5'b0, plr_1_pnd}, 6'd0);
        step();
        check("prio pnd", {5'b0, plr_1_pnd}, 6'd1);
        plr_1_btn = 6'b001000;
        run(8);
        plr_1_btn = 6'b101000;
        run(8);
        check("prio still pnd", {5'b0, plr_1_pnd}, 6'd1);
        tick();
        check_outs("prio tck", 6'b001000, '0, 1'b0, 1'b0);
        step();
        tick();
        check_outs("prio tck2", '0, '0, 1'b0, 1'b0);

        // Press landing on the tick cycle waits for the next tick.
        do_reset();
        plr_1_btn = 6'b000001;
        run(5);
        check("ontck pre", {5'b0, plr_1_pnd}, 6'd0);
        tick();
        check_outs("ontck tck", '0, '0, 1'b1, 1'b0);
        run(3);
        tick();
        check_outs("ontck tck2", 6'b000001, '0, 1'b0, 1'b0);

        // Both players together.
        do_reset();
        plr_1_btn = 6'b000010;
        plr_2_btn = 6'b010000;
        run(6);
        check_outs("both pnd", '0, '0, 1'b1, 1'b1);
        tick();
        check_outs("both tck", 6'b000010, 6'b010000, 1'b0, 1'b0);
        tick();
        check_outs("both tck2", '0, '0, 1'b0, 1'b0);

        // Reset beats tick; a short hold after reset and release gives no event.
        do_reset();
        plr_1_btn = 6'b000100;
        run(6);
        check("rsttck pre", {5'b0, plr_1_pnd}, 6'd1);
        rst = 1'b1;
        tck = 1'b1;
        step();
        rst = 1'b0;
        tck = 1'b0;
        check_outs("rsttck", '0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("rsttck hold %0d", i), {5'b0, plr_1_pnd}, 6'd0);
        end
        plr_1_btn = '0;
        run(10);
        check("rsttck released", {5'b0, plr_1_pnd}, 6'd0);
        plr_1_btn = 6'b000100;
        run(5);
        check("rsttck repress early", {5'b0, plr_1_pnd}, 6'd0);
        step();
        check("rsttck repress", {5'b0, plr_1_pnd}, 6'd1);

        // Button held through reset release: one press exactly 2+DBNC edges later.
        plr_1_btn = 6'b010000;
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        run(5);
        check("heldrst early", {5'b0, plr_1_pnd}, 6'd0);
        step();
        check_outs("heldrst", '0, '0, 1'b1, 1'b0);

        // Random stimulus against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < AW; b++) begin
                if ($urandom_range(0, 15) == 0) plr_1_btn[b] = ~plr_1_btn[b];
                if ($urandom_range(0, 15) == 0) plr_2_btn[b] = ~plr_2_btn[b];
            end
            tck = ($urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 299) == 0);
            step();
            check_outs($sformatf("rand %0d", c), oh(m_act[0]), oh(m_act[1]),
                       m_pend[0] >= 0, m_pend[1] >= 0);
        end
        rst = 1'b0;
        tck = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
